// File: rtl/hazard_forward_unit_pkg.sv
// Shared definitions for the hazard/forwarding unit: operand-mux select codes and miss FSM states.
package hazard_forward_unit_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MISS    = 2'b01,
        ST_TIMEOUT = 2'b10
    } miss_state_e;

endpackage

// File: rtl/hazard_forward_unit_sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones, synchronous active-high clear.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Pipeline hazard control: EX forwarding selects, load-use bubbles, D-cache miss freeze with
// watchdog, and saturating stall counters.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int unsigned RA_W     = 5,
    parameter int unsigned MISS_MAX = 64,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RA_W-1:0]  rs1_d,
    input  logic [RA_W-1:0]  rs2_d,
    input  logic [RA_W-1:0]  rs1_e,
    input  logic [RA_W-1:0]  rs2_e,
    input  logic [RA_W-1:0]  rd_e,
    input  logic             mem_read_e,
    input  logic             pc_src_e,
    input  logic [RA_W-1:0]  rd_m,
    input  logic             reg_write_m,
    input  logic [RA_W-1:0]  rd_w,
    input  logic             reg_write_w,
    input  logic             mem_req_m,
    input  logic             cache_ready,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             miss_busy,
    output logic             miss_timeout,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] miss_cyc_cnt
);

    localparam int unsigned CTR_W = $clog2(MISS_MAX + 1);

    miss_state_e      state, state_next;
    logic [CTR_W-1:0] miss_ctr, miss_ctr_next;
    logic             timeout_next;
    logic             mem_stall;
    logic             lu_stall;
    logic [1:0]       fwd_a, fwd_b;

    assign mem_stall = mem_req_m & ~cache_ready;
    assign lu_stall  = mem_read_e & (rd_e != '0) & ((rd_e == rs1_d) | (rd_e == rs2_d));

    // MEM result is younger than WB, so it wins when both match
    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs1_e)) begin
            fwd_a = FWD_MEM;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs1_e)) begin
            fwd_a = FWD_WB;
        end
        if (reg_write_m && (rd_m != '0) && (rd_m == rs2_e)) begin
            fwd_b = FWD_MEM;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs2_e)) begin
            fwd_b = FWD_WB;
        end
    end

    // Flushes wait out a freeze; pc_src_e is held in EX so the redirect lands exactly once
    always_comb begin
        fwd_a_e   = fwd_a;
        fwd_b_e   = fwd_b;
        stall_f   = mem_stall | lu_stall;
        stall_d   = mem_stall | lu_stall;
        stall_e   = mem_stall;
        stall_m   = mem_stall;
        flush_d   = pc_src_e & ~mem_stall;
        flush_e   = (pc_src_e | lu_stall) & ~mem_stall;
        miss_busy = (state != ST_RUN);
        if (rst) begin
            fwd_a_e   = FWD_REG;
            fwd_b_e   = FWD_REG;
            stall_f   = 1'b0;
            stall_d   = 1'b0;
            stall_e   = 1'b0;
            stall_m   = 1'b0;
            flush_d   = 1'b1;
            flush_e   = 1'b1;
            miss_busy = 1'b0;
        end
    end

    // Miss tracking next-state
    always_comb begin
        state_next    = state;
        miss_ctr_next = miss_ctr;
        timeout_next  = miss_timeout;
        case (state)
            ST_RUN: begin
                if (mem_stall) begin
                    state_next    = ST_MISS;
                    miss_ctr_next = CTR_W'(1);
                end
            end
            ST_MISS: begin
                if (cache_ready || !mem_req_m) begin
                    state_next    = ST_RUN;
                    miss_ctr_next = '0;
                end else if (miss_ctr == CTR_W'(MISS_MAX - 1)) begin
                    state_next   = ST_TIMEOUT;
                    timeout_next = 1'b1;
                end else begin
                    miss_ctr_next = miss_ctr + CTR_W'(1);
                end
            end
            ST_TIMEOUT: begin
                if (cache_ready || !mem_req_m) begin
                    state_next    = ST_RUN;
                    miss_ctr_next = '0;
                end
            end
            default: begin
                state_next    = ST_RUN;
                miss_ctr_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            miss_ctr     <= '0;
            miss_timeout <= 1'b0;
        end else begin
            state        <= state_next;
            miss_ctr     <= miss_ctr_next;
            miss_timeout <= timeout_next;
        end
    end

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk (clk),
        .rst (rst),
        .inc (lu_stall & ~mem_stall),
        .q   (lu_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk (clk),
        .rst (rst),
        .inc (mem_stall),
        .q   (miss_cyc_cnt)
    );

endmodule
